// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event scheduler: captures per-channel rising/falling edges as
// pending events and hands them one at a time to a valid/ready consumer in round-robin order.
module edge_event_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [NUM_CH-1:0] data_in,
    input  logic [NUM_CH-1:0] rise_en,
    input  logic [NUM_CH-1:0] fall_en,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [IDX_W-1:0]  evt_ch,
    output logic              evt_type,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overflow,
    input  logic [NUM_CH-1:0] ovf_clr
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [NUM_CH-1:0] data_dly_r;
    logic [NUM_CH-1:0] pending_r;
    logic [NUM_CH-1:0] ptype_r;
    logic [NUM_CH-1:0] overflow_r;
    logic [NUM_CH-1:0] rise_s;
    logic [NUM_CH-1:0] fall_s;
    logic [NUM_CH-1:0] det_s;
    logic [NUM_CH-1:0] grant_s;
    logic [NUM_CH-1:0] pending_nxt_s;
    logic [NUM_CH-1:0] ptype_nxt_s;
    logic [NUM_CH-1:0] overflow_nxt_s;
    logic [IDX_W-1:0]  ptr_r;
    logic [IDX_W-1:0]  ptr_nxt_s;
    logic [IDX_W-1:0]  sel_s;
    logic [IDX_W:0]    idx_s;
    logic              found_s;
    logic              any_pend_s;
    logic              load_s;
    logic              evt_valid_r;
    logic              evt_type_r;
    logic [IDX_W-1:0]  evt_ch_r;

    assign rise_s     = {NUM_CH{ena}} & data_in & ~data_dly_r & rise_en;
    assign fall_s     = {NUM_CH{ena}} & ~data_in & data_dly_r & fall_en;
    assign det_s      = rise_s | fall_s;
    assign any_pend_s = |pending_r;

    // Round-robin pick: first pending channel at or after ptr, wrapping modulo NUM_CH
    always_comb begin
        sel_s   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx_s = {1'b0, ptr_r} + (IDX_W+1)'(k);
            if (idx_s >= (IDX_W+1)'(NUM_CH)) begin
                idx_s = idx_s - (IDX_W+1)'(NUM_CH);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && pending_r[idx_s[IDX_W-1:0]]) begin
                sel_s   = idx_s[IDX_W-1:0];
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        if (sel_s == (IDX_W)'(NUM_CH-1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = sel_s + (IDX_W)'(1);
        end
    end

    // Handshake FSM: decides when a new event is loaded into the output stage
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_pend_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = OFFER;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    if (any_pend_s) begin
                        load_s      = 1'b1;
                        state_nxt_s = OFFER;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = OFFER;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Per-channel pending/type/overflow update; a re-edge on the channel being granted re-arms it
    always_comb begin
        grant_s        = '0;
        pending_nxt_s  = pending_r;
        ptype_nxt_s    = ptype_r;
        overflow_nxt_s = overflow_r;
        for (int i = 0; i < NUM_CH; i++) begin
            grant_s[i] = load_s && (sel_s == (IDX_W)'(i));
            if (det_s[i]) begin
                if (!pending_r[i] || grant_s[i]) begin
                    pending_nxt_s[i] = 1'b1;
                    ptype_nxt_s[i]   = rise_s[i];
                end else begin
                    overflow_nxt_s[i] = 1'b1;
                end
            end else if (grant_s[i]) begin
                pending_nxt_s[i] = 1'b0;
            end else begin
                pending_nxt_s[i] = pending_r[i];
            end
            if (ovf_clr[i] && !(det_s[i] && pending_r[i] && !grant_s[i])) begin
                overflow_nxt_s[i] = 1'b0;
            end else begin
                overflow_nxt_s[i] = overflow_nxt_s[i];
            end
        end
    end

    // State, history and event-flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            data_dly_r <= '0;
            pending_r  <= '0;
            ptype_r    <= '0;
            overflow_r <= '0;
            ptr_r      <= '0;
        end else begin
            state_r    <= state_nxt_s;
            data_dly_r <= ena ? data_in : data_dly_r;
            pending_r  <= pending_nxt_s;
            ptype_r    <= ptype_nxt_s;
            overflow_r <= overflow_nxt_s;
            ptr_r      <= load_s ? ptr_nxt_s : ptr_r;
        end
    end

    // Output stage: holds the offered event stable until it is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid_r <= 1'b0;
            evt_ch_r    <= '0;
            evt_type_r  <= 1'b0;
        end else if (load_s) begin
            evt_valid_r <= 1'b1;
            evt_ch_r    <= sel_s;
            evt_type_r  <= ptype_r[sel_s];
        end else if ((state_r == OFFER) && evt_ready) begin
            evt_valid_r <= 1'b0;
        end else begin
            evt_valid_r <= evt_valid_r;
        end
    end

    assign evt_valid = evt_valid_r;
    assign evt_ch    = evt_ch_r;
    assign evt_type  = evt_type_r;
    assign pending   = pending_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter: capture, round robin,
// backpressure/overflow, masking, grant/re-edge collision and async reset.
module tb_edge_event_arbiter;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [3:0] data_in;
    logic [3:0] rise_en;
    logic [3:0] fall_en;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic       evt_type;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic [3:0] ovf_clr;

    int checks_cnt;
    int fail_cnt;

    edge_event_arbiter #(.NUM_CH(4), .IDX_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .data_in   (data_in),
        .rise_en   (rise_en),
        .fall_en   (fall_en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_type  (evt_type),
        .pending   (pending),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_evt(input string tag, input logic v, input logic [1:0] ch, input logic t);
        check_val({tag, "_valid"}, {31'd0, evt_valid}, {31'd0, v});
        if (v) begin
            check_val({tag, "_ch"}, {30'd0, evt_ch}, {30'd0, ch});
            check_val({tag, "_type"}, {31'd0, evt_type}, {31'd0, t});
        end
    endtask

    task automatic do_reset();
        data_in = 4'b0000;
        rst     = 1'b1;
        tick();
        rst     = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst        = 1'b1;
        ena        = 1'b0;
        data_in    = 4'b0000;
        rise_en    = 4'b0000;
        fall_en    = 4'b0000;
        evt_ready  = 1'b0;
        ovf_clr    = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        check_evt("reset", 1'b0, 2'd0, 1'b0);
        check_val("reset_ch", {30'd0, evt_ch}, 32'd0);
        check_val("reset_pend", {28'd0, pending}, 32'd0);
        check_val("reset_ovf", {28'd0, overflow}, 32'd0);

        // Basic rise on ch0
        ena = 1'b1; rise_en = 4'b0001; evt_ready = 1'b1;
        data_in = 4'b0001;
        tick();
        check_val("basic_pend", {28'd0, pending}, 32'h1);
        check_evt("basic_n", 1'b0, 2'd0, 1'b0);
        tick();
        check_evt("basic_n1", 1'b1, 2'd0, 1'b1);
        tick();
        check_evt("basic_n2", 1'b0, 2'd0, 1'b0);
        check_val("basic_pend_end", {28'd0, pending}, 32'h0);

        // Round robin, all four together
        do_reset();
        rise_en = 4'hF; fall_en = 4'hF; evt_ready = 1'b1; ena = 1'b1;
        data_in = 4'hF;
        tick();
        check_val("rr_pend", {28'd0, pending}, 32'hF);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_evt("rr_seq", 1'b1, 2'(k), 1'b1);
        end
        tick();
        check_evt("rr_idle", 1'b0, 2'd0, 1'b0);
        // Falling edges with fall_en=0 produce nothing
        fall_en = 4'h0;
        data_in = 4'h0;
        tick();
        check_val("mask_fall_pend", {28'd0, pending}, 32'h0);
        tick();
        check_evt("mask_fall_evt", 1'b0, 2'd0, 1'b0);
        // ch0 and ch2 with ptr wrapped to 0
        data_in = 4'b0101;
        tick();
        tick();
        check_evt("rr_wrap0", 1'b1, 2'd0, 1'b1);
        tick();
        check_evt("rr_wrap2", 1'b1, 2'd2, 1'b1);
        tick();
        check_evt("rr_wrap_idle", 1'b0, 2'd0, 1'b0);
        // Move ptr to 1 via a lone ch0 grant, then ch0+ch2 pending -> ch2 first
        data_in = 4'b0000;
        tick();
        data_in = 4'b0001;
        tick();
        tick();
        check_evt("rr_ptr1_ch0", 1'b1, 2'd0, 1'b1);
        tick();
        data_in = 4'b0000;
        tick();
        data_in = 4'b0101;
        tick();
        check_val("rr_ptr1_pend", {28'd0, pending}, 32'h5);
        tick();
        check_evt("rr_ptr1_first", 1'b1, 2'd2, 1'b1);
        tick();
        check_evt("rr_ptr1_second", 1'b1, 2'd0, 1'b1);

        // Backpressure and overflow on ch1
        do_reset();
        rise_en = 4'hF; fall_en = 4'hF; evt_ready = 1'b0; ena = 1'b1;
        data_in = 4'b0010;
        tick();
        tick();
        check_evt("bp_offer", 1'b1, 2'd1, 1'b1);
        check_val("bp_pend0", {28'd0, pending}, 32'h0);
        data_in = 4'b0000;
        tick();
        check_val("bp_pend_fall", {28'd0, pending}, 32'h2);
        check_evt("bp_hold", 1'b1, 2'd1, 1'b1);
        check_val("bp_ovf0", {28'd0, overflow}, 32'h0);
        data_in = 4'b0010;
        tick();
        check_val("bp_ovf_set", {28'd0, overflow}, 32'h2);
        check_val("bp_pend_keep", {28'd0, pending}, 32'h2);
        evt_ready = 1'b1;
        tick();
        check_evt("bp_next_fall", 1'b1, 2'd1, 1'b0);
        check_val("bp_pend_drain", {28'd0, pending}, 32'h0);
        tick();
        check_evt("bp_idle", 1'b0, 2'd0, 1'b0);
        check_val("bp_ovf_sticky", {28'd0, overflow}, 32'h2);
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = 4'b0000;
        check_val("bp_ovf_clr", {28'd0, overflow}, 32'h0);

        // ena gating of history register
        do_reset();
        rise_en = 4'hF; fall_en = 4'h0; evt_ready = 1'b1; ena = 1'b0;
        data_in = 4'b0001;
        tick();
        data_in = 4'b0000;
        tick();
        data_in = 4'b0001;
        tick();
        check_val("ena0_pend", {28'd0, pending}, 32'h0);
        check_evt("ena0_evt", 1'b0, 2'd0, 1'b0);
        ena = 1'b1;
        tick();
        check_val("ena1_pend", {28'd0, pending}, 32'h1);
        tick();
        check_evt("ena1_evt", 1'b1, 2'd0, 1'b1);
        tick();
        check_evt("ena1_idle", 1'b0, 2'd0, 1'b0);

        // Grant of ch2 colliding with a new ch2 edge
        do_reset();
        rise_en = 4'hF; fall_en = 4'hF; evt_ready = 1'b1; ena = 1'b1;
        data_in = 4'b0100;
        tick();
        data_in = 4'b0000;
        tick();
        check_evt("coll_first", 1'b1, 2'd2, 1'b1);
        check_val("coll_pend", {28'd0, pending}, 32'h4);
        check_val("coll_ovf", {28'd0, overflow}, 32'h0);
        tick();
        check_evt("coll_second", 1'b1, 2'd2, 1'b0);
        tick();
        check_evt("coll_idle", 1'b0, 2'd0, 1'b0);
        check_val("coll_ovf_end", {28'd0, overflow}, 32'h0);

        // Async reset mid-offer, ptr left at 3 beforehand
        evt_ready = 1'b0;
        data_in = 4'b0100;
        tick();
        tick();
        check_evt("rmo_offer", 1'b1, 2'd2, 1'b1);
        data_in = 4'b0000;
        tick();
        data_in = 4'b0100;
        tick();
        check_val("rmo_pre_ovf", {28'd0, overflow}, 32'h4);
        #2;
        rst = 1'b1;
        #1;
        check_val("rmo_valid", {31'd0, evt_valid}, 32'd0);
        check_val("rmo_pend", {28'd0, pending}, 32'h0);
        check_val("rmo_ovf", {28'd0, overflow}, 32'h0);
        data_in = 4'b0000;
        tick();
        rst = 1'b0;
        evt_ready = 1'b1;
        data_in = 4'hF;
        tick();
        tick();
        check_evt("rmo_first_ch0", 1'b1, 2'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
